// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_pkg
//  Description : Shared definitions for the UART TX arbiter: FSM state
//                encodings, default byte width and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    // Arbiter FSM states; explicit 1-bit encoding.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Default byte width of the UART TX data path.
    localparam int UART_DATA_WIDTH = 8;

    // Width of an index into N items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_sel
//  Description : Combinational round-robin priority search. Returns the first
//                asserted request at or after ptr, searching upward modulo N.
//  Ports       : req  - request vector (N bits)
//                ptr  - index holding highest priority
//                pick - one-hot selected request, zero when req is zero
//                idx  - index of the selected request, zero when req is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_sel
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest request at or
    // after ptr is the last one written and therefore wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                pick                          = '0;
                pick[(int'(ptr) + off) % N]   = 1'b1;
                idx                           = IW'((int'(ptr) + off) % N);
            end
        end
    end

endmodule : rr_priority_sel
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART TX FIFO write port among N_REQ requesters.
//                A requester is locked in as owner for a whole frame (until
//                its i_last byte is written) so frames never interleave.
//                An owner that stops requesting for TIMEOUT cycles is forcibly
//                released and o_err pulses for one cycle.
//  Ports       : i_clk      - clock, rising edge
//                i_reset    - asynchronous active-high reset
//                i_req      - per-requester byte valid
//                i_data     - packed bytes, requester k at [k*DATA_WIDTH +:]
//                i_last     - per-requester end-of-frame flag
//                i_tx_full  - TX FIFO full (backpressure)
//                o_gnt      - one-hot byte-accepted strobe to the owner
//                o_w_data   - byte to the TX FIFO
//                o_wr_uart  - TX FIFO write strobe
//                o_busy     - a requester owns the port
//                o_owner    - current owner index, 0 when not busy
//                o_err      - one-cycle pulse after a timeout release
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
    input  logic [N_REQ-1:0]            i_last,
    input  logic                        i_tx_full,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [DATA_WIDTH-1:0]       o_w_data,
    output logic                        o_wr_uart,
    output logic                        o_busy,
    output logic [idx_width(N_REQ)-1:0] o_owner,
    output logic                        o_err
);

    localparam int OW = idx_width(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e       state_q,  state_d;
    logic [OW-1:0]    owner_q,  owner_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    tmo_q,    tmo_d;
    logic             err_q,    err_d;

    logic [N_REQ-1:0]      pick;
    logic [OW-1:0]         pick_idx;
    logic                  any_req;
    logic                  owner_req;
    logic                  accept;
    logic [OW-1:0]         owner_next;
    logic [DATA_WIDTH-1:0] owner_data;

    rr_priority_sel #(
        .N  (N_REQ),
        .IW (OW)
    ) u_rr_sel (
        .req  (i_req),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    assign any_req    = |pick;
    assign owner_req  = i_req[owner_q];
    assign owner_data = i_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign owner_next = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        accept    = 1'b0;
        o_gnt     = '0;
        o_wr_uart = 1'b0;
        o_w_data  = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_LOCKED;
                    owner_d = pick_idx;
                    tmo_d   = '0;
                end
            end

            ST_LOCKED: begin
                // Byte is presented even while stalled so the FIFO side
                // sees a stable value.
                o_w_data = owner_data;
                accept   = owner_req & ~i_tx_full;
                if (accept) begin
                    o_wr_uart      = 1'b1;
                    o_gnt[owner_q] = 1'b1;
                    tmo_d          = '0;
                    if (i_last[owner_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_next;
                        owner_d  = '0;
                    end
                end else if (!owner_req) begin
                    // Only an absent owner request ages the lock; a full
                    // FIFO leaves the counter where it is.
                    if (tmo_q == CW'(TIMEOUT - 1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_next;
                        owner_d  = '0;
                        tmo_d    = '0;
                        err_d    = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy  = (state_q == ST_LOCKED);
    assign o_owner = o_busy ? owner_q : '0;
    assign o_err   = err_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the byte width of the UART TX data path.
REQ-002 The block SHALL have parameter N_REQ, default 4, the number of requesters sharing one UART TX FIFO write port.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the idle cycles allowed to a lock owner before forced release.
REQ-004 i_clk  input  1  clock; all state changes on the rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_req  input  N_REQ  per-requester byte-valid; held high with stable data until granted.
REQ-007 i_data  input  N_REQ*DATA_WIDTH  packed bytes; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 i_last  input  N_REQ  per-requester flag: the current byte ends the frame.
REQ-009 i_tx_full  input  1  UART TX FIFO full.
REQ-010 o_gnt  output  N_REQ  one-hot byte-accepted strobe to the owner; all zero otherwise.
REQ-011 o_w_data  output  DATA_WIDTH  byte to the UART TX FIFO.
REQ-012 o_wr_uart  output  1  TX FIFO write strobe.
REQ-013 o_busy  output  1  high while a requester owns the port.
REQ-014 o_owner  output  clog2(N_REQ)  index of the current owner; 0 when not busy.
REQ-015 o_err  output  1  one-cycle registered pulse on a timeout release.

Function
REQ-016 The FSM SHALL have two states: IDLE (no owner) and LOCKED (owner latched).
REQ-017 In IDLE, when any i_req bit is high, the block SHALL select the first requesting index at or after rr_ptr, searching upward modulo N_REQ, latch it as owner and enter LOCKED on the next edge.
REQ-018 In IDLE, o_gnt and o_wr_uart SHALL be 0; arbitration latency is one cycle from request to ownership.
REQ-019 In LOCKED, accept = i_req[owner] AND NOT i_tx_full, evaluated combinationally.
REQ-020 On accept, o_wr_uart SHALL be 1, o_gnt[owner] SHALL be 1 and o_w_data SHALL equal the owner's i_data slice, all in the same cycle.
REQ-021 In LOCKED with no accept, o_wr_uart SHALL be 0, o_gnt SHALL be 0 and o_w_data SHALL hold the owner's slice.
REQ-022 On accept with i_last[owner]=1, the block SHALL return to IDLE and set rr_ptr = (owner+1) mod N_REQ.
REQ-023 Non-owner requests SHALL be ignored while LOCKED, so frames never interleave.
REQ-024 A timeout counter SHALL increment each LOCKED cycle in which i_req[owner]=0, and SHALL clear on accept and on entry to LOCKED.
REQ-025 Cycles with i_req[owner]=1 and i_tx_full=1 SHALL hold the timeout counter unchanged, because FIFO backpressure is not a requester fault.
REQ-026 When the counter reaches TIMEOUT, the block SHALL go to IDLE, advance rr_ptr as in REQ-022, and pulse o_err high for exactly the next cycle.
REQ-027 o_busy SHALL be 1 exactly in LOCKED; o_owner SHALL be valid whenever o_busy=1.
REQ-028 A single-byte frame (i_last=1 on the first byte) SHALL be legal: one write, then IDLE.
REQ-029 Back-to-back frames SHALL incur exactly one IDLE cycle between the last write of one frame and the first write of the next.

Reset
REQ-030 While i_reset=1, the block SHALL hold state IDLE, rr_ptr=0, owner=0, timeout counter=0, o_err=0.
REQ-031 While i_reset=1, combinational outputs SHALL be o_gnt=0, o_wr_uart=0, o_busy=0, o_owner=0, o_w_data=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; no further writes SHALL occur for it, and arbitration SHALL restart from index 0.

Structure
REQ-033 The shared UART package SHALL hold the state encodings (IDLE=1'b0, LOCKED=1'b1) and the default DATA_WIDTH.
REQ-034 The round-robin priority search SHALL be the sub-module rr_priority_sel: combinational, inputs req and ptr, outputs a one-hot pick and its index.

Verification
REQ-035 req0 high, data0=0x41, last0=1, tx_full=0 -> one IDLE cycle, then o_wr_uart=1, o_w_data=0x41, o_gnt=4'b0001 for 1 cycle, then IDLE.
REQ-036 req0 and req2 high at the same time, 2-byte frames (0x10,0x11 / 0x20,0x21) -> FIFO receives 0x10,0x11,0x20,0x21, then the next arbitration starts at index 3.
REQ-037 Owner 1 mid-frame with tx_full=1 for 40 cycles -> no write, no o_err; on tx_full=0 the held byte is written once.
REQ-038 Owner 3 drops req after the first byte -> after 16 idle cycles the block enters IDLE, o_err pulses once, and rr_ptr=0.
REQ-039 Owner 2 locked while req1 toggles -> no o_gnt[1] until owner 2's last byte; req1 is then granted after one IDLE cycle.
REQ-040 i_reset pulsed while owner 1 is mid-frame -> outputs are immediately zero and the block is in IDLE; a later req1 restarts arbitration from index 0.
